// File: rtl/bus_fabric.sv
// N-source priority bus mux with optional output register, idle hold, contention logging and transfer count.
// Latency 0 or 1 cycle (REG_OUT); no backpressure, a request is resolved every cycle.
module bus_fabric #(
  parameter int               WIDTH     = 32,
  parameter int               N_SRC     = 6,
  parameter bit               REG_OUT   = 1'b1,
  parameter bit               HOLD_LAST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_VAL  = '0,
  parameter int               CNT_W     = 16,
  localparam int              OW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       src_rd,
  output logic [WIDTH-1:0]       bus,
  output logic                   bus_valid,
  output logic [OW-1:0]          bus_owner,
  output logic                   conflict,
  output logic                   conflict_sticky,
  output logic [N_SRC-1:0]       conflict_mask,
  input  logic                   clr_err,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       xfer_count
);

  logic [WIDTH-1:0] sel_dat;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] hold_dat;
  logic [OW-1:0]    sel_idx;
  logic             sel_vld;
  logic             multi;

  // During reset the held register is about to be cleared, so show IDLE_VAL already.
  assign hold_dat = (HOLD_LAST && !rst) ? last_q : IDLE_VAL;

  // Descending scan so the lowest set index is the last assignment and wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_dat = hold_dat;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_rd[i]) begin
        sel_vld = 1'b1;
        sel_idx = OW'(i);
        sel_dat = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign multi = (src_rd & (src_rd - N_SRC'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDLE_VAL;
    end else if (sel_vld) begin
      last_q <= sel_dat;
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      always_ff @(posedge clk) begin
        if (rst) begin
          bus       <= IDLE_VAL;
          bus_valid <= 1'b0;
          bus_owner <= '0;
        end else begin
          bus       <= sel_dat;
          bus_valid <= sel_vld;
          bus_owner <= sel_idx;
        end
      end
    end else begin : g_comb_out
      assign bus       = sel_dat;
      assign bus_valid = sel_vld;
      assign bus_owner = sel_idx;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      conflict_mask   <= '0;
    end else begin
      conflict <= multi;
      if (multi) begin
        conflict_sticky <= 1'b1;
      end else if (clr_err) begin
        conflict_sticky <= 1'b0;
      end
      // A clear in the same cycle as contention re-arms capture for the new offender.
      if (multi && (!conflict_sticky || clr_err)) begin
        conflict_mask <= src_rd;
      end else if (clr_err) begin
        conflict_mask <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      xfer_count <= '0;
    end else if (sel_vld && (xfer_count != {CNT_W{1'b1}})) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench: three bus_fabric variants on shared inputs, checked against hand-computed values.
module tb_bus_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic [191:0] src_data;
  logic [5:0]   src_rd;
  logic         clr_err;
  logic         cnt_clr;

  // a: REG_OUT=1, HOLD_LAST=1; b: REG_OUT=1, HOLD_LAST=0, IDLE=FFFFFFFF, CNT_W=4; c: REG_OUT=0
  logic [31:0] a_bus, b_bus, c_bus;
  logic        a_vld, b_vld, c_vld;
  logic [2:0]  a_own, b_own, c_own;
  logic        a_cf, b_cf, c_cf;
  logic        a_st, b_st, c_st;
  logic [5:0]  a_msk, b_msk, c_msk;
  logic [15:0] a_cnt, c_cnt;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bus_fabric #(.REG_OUT(1'b1), .HOLD_LAST(1'b1)) u_a (
    .clk(clk), .rst(rst), .src_data(src_data), .src_rd(src_rd),
    .bus(a_bus), .bus_valid(a_vld), .bus_owner(a_own), .conflict(a_cf),
    .conflict_sticky(a_st), .conflict_mask(a_msk), .clr_err(clr_err),
    .cnt_clr(cnt_clr), .xfer_count(a_cnt));

  bus_fabric #(.REG_OUT(1'b1), .HOLD_LAST(1'b0), .IDLE_VAL(32'hFFFF_FFFF), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .src_data(src_data), .src_rd(src_rd),
    .bus(b_bus), .bus_valid(b_vld), .bus_owner(b_own), .conflict(b_cf),
    .conflict_sticky(b_st), .conflict_mask(b_msk), .clr_err(clr_err),
    .cnt_clr(cnt_clr), .xfer_count(b_cnt));

  bus_fabric #(.REG_OUT(1'b0), .HOLD_LAST(1'b1)) u_c (
    .clk(clk), .rst(rst), .src_data(src_data), .src_rd(src_rd),
    .bus(c_bus), .bus_valid(c_vld), .bus_owner(c_own), .conflict(c_cf),
    .conflict_sticky(c_st), .conflict_mask(c_msk), .clr_err(clr_err),
    .cnt_clr(cnt_clr), .xfer_count(c_cnt));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    src_rd   = '0;
    clr_err  = 1'b0;
    cnt_clr  = 1'b0;
    src_data = {32'h0000_0055, 32'h0000_0044, 32'h0000_0033,
                32'hDEAD_BEEF, 32'h0000_0011, 32'hA0A0_A0A0};
    tick();
    check("rst_a_bus", a_bus, 32'h0);
    check("rst_a_vld", a_vld, 1'b0);
    check("rst_a_own", a_own, 3'd0);
    check("rst_a_cf", a_cf, 1'b0);
    check("rst_a_st", a_st, 1'b0);
    check("rst_a_msk", a_msk, 6'b0);
    check("rst_a_cnt", a_cnt, 16'd0);
    check("rst_b_bus", b_bus, 32'hFFFF_FFFF);

    rst = 1'b0;
    repeat (3) tick();
    check("idle_b_bus", b_bus, 32'hFFFF_FFFF);
    check("idle_b_cnt", b_cnt, 4'd0);
    check("idle_a_bus", a_bus, 32'h0);

    src_rd = 6'b000100;
    #1;
    check("comb_c_bus", c_bus, 32'hDEAD_BEEF);
    check("comb_c_vld", c_vld, 1'b1);
    check("comb_c_own", c_own, 3'd2);
    tick();
    check("single_a_bus", a_bus, 32'hDEAD_BEEF);
    check("single_a_vld", a_vld, 1'b1);
    check("single_a_own", a_own, 3'd2);
    check("single_a_cnt", a_cnt, 16'd1);

    src_rd = 6'b000000;
    #1;
    check("hold_c_bus", c_bus, 32'hDEAD_BEEF);
    check("hold_c_vld", c_vld, 1'b0);
    tick();
    check("hold_a_bus", a_bus, 32'hDEAD_BEEF);
    check("hold_a_vld", a_vld, 1'b0);
    check("hold_a_own", a_own, 3'd0);
    check("nohold_b_bus", b_bus, 32'hFFFF_FFFF);

    src_rd = 6'b010010;
    tick();
    check("cont_a_bus", a_bus, 32'h11);
    check("cont_a_own", a_own, 3'd1);
    check("cont_a_cf", a_cf, 1'b1);
    check("cont_a_st", a_st, 1'b1);
    check("cont_a_msk", a_msk, 6'b010010);

    src_rd = 6'b000011;
    tick();
    check("cont2_a_cf", a_cf, 1'b1);
    check("cont2_a_msk", a_msk, 6'b010010);
    check("cont2_a_bus", a_bus, 32'hA0A0_A0A0);
    check("cont2_a_cnt", a_cnt, 16'd3);

    src_rd = 6'b000000;
    tick();
    check("cfdrop_a_cf", a_cf, 1'b0);
    check("cfdrop_a_st", a_st, 1'b1);

    clr_err = 1'b1;
    tick();
    check("clr_a_st", a_st, 1'b0);
    check("clr_a_msk", a_msk, 6'b0);

    src_rd = 6'b100001;
    tick();
    clr_err = 1'b0;
    check("clrcont_a_st", a_st, 1'b1);
    check("clrcont_a_msk", a_msk, 6'b100001);
    check("clrcont_a_cnt", a_cnt, 16'd4);

    src_rd  = 6'b000100;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cntclr_a_cnt", a_cnt, 16'd0);
    check("cntclr_b_cnt", b_cnt, 4'd0);
    check("cntclr_a_bus", a_bus, 32'hDEAD_BEEF);

    src_rd = 6'b001000;
    repeat (20) tick();
    check("sat_b_cnt", b_cnt, 4'd15);
    check("sat_a_cnt", a_cnt, 16'd20);
    check("sat_b_bus", b_bus, 32'h33);

    rst    = 1'b1;
    src_rd = 6'b000000;
    #1;
    check("rstidle_c_bus", c_bus, 32'h0);
    src_rd = 6'b000011;
    #1;
    check("rstcomb_c_bus", c_bus, 32'hA0A0_A0A0);
    check("rstcomb_c_vld", c_vld, 1'b1);
    check("rstcomb_c_own", c_own, 3'd0);
    tick();
    check("rstx_a_bus", a_bus, 32'h0);
    check("rstx_a_vld", a_vld, 1'b0);
    check("rstx_a_cf", a_cf, 1'b0);
    check("rstx_a_st", a_st, 1'b0);
    check("rstx_a_msk", a_msk, 6'b0);
    check("rstx_a_cnt", a_cnt, 16'd0);
    check("rstx_b_bus", b_bus, 32'hFFFF_FFFF);
    check("rstx_c_st", c_st, 1'b0);
    check("rstx_c_cnt", c_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
